// File: rtl/pcileech_board_ctl_pkg.sv
// Shared types and helpers for the PCILeech board housekeeping block.
package pcileech_board_ctl_pkg;

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_BTN  = 2'd1,
      ST_RUN  = 2'd2
   } board_rst_state_t;

   // Width of a counter that must be able to hold the value max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/pcileech_board_ctl_if.sv
// Pad-side bundle of the board housekeeping block: buttons, activity strobes, reset and LEDs.
interface pcileech_board_ctl_if #(
   parameter int unsigned NUM_BTN = 2,
   parameter int unsigned NUM_LED = 2
);
   logic [NUM_BTN-1:0] btn_n;
   logic [NUM_LED-1:0] led_act;
   logic               led_invert;
   logic [NUM_BTN-1:0] btn_level;
   logic [NUM_BTN-1:0] btn_press;
   logic               rst_out;
   logic [NUM_LED-1:0] led_out;

   modport master (
      output btn_n, led_act, led_invert,
      input  btn_level, btn_press, rst_out, led_out
   );

   modport slave (
      input  btn_n, led_act, led_invert,
      output btn_level, btn_press, rst_out, led_out
   );
endinterface

// File: rtl/pcileech_debounce.sv
// Single-button debouncer: 2-flop synchroniser, stability counter, level and press outputs.
module pcileech_debounce
   import pcileech_board_ctl_pkg::*;
#(
   parameter int unsigned CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic level,
   output logic press,
   output logic level_d
);

   localparam int unsigned         CNT_W    = cnt_width(CYCLES);
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(CYCLES - 1);

   logic [1:0]       sync;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             pressed;
   logic             flip;

   assign pressed = ~sync[1];

   always_comb begin
      cnt_nxt = cnt;
      flip    = 1'b0;
      if (pressed == level) begin
         cnt_nxt = '0;
      end else if (cnt == CNT_LAST) begin
         flip    = 1'b1;
         cnt_nxt = '0;
      end else begin
         cnt_nxt = cnt + 1'b1;
      end
   end

   // level_d is the value level takes at the coming edge; lets the reset FSM react in step with it.
   assign level_d = level ^ flip;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync  <= '1;
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], btn_n};
         cnt   <= cnt_nxt;
         level <= level_d;
         press <= flip & ~level;
      end
   end

endmodule

// File: rtl/pcileech_board_ctl.sv
// Board housekeeping: button debounce, system reset sequencing and stretched activity LEDs.
module pcileech_board_ctl
   import pcileech_board_ctl_pkg::*;
#(
   parameter int unsigned PARAM_NUM_BTN         = 2,
   parameter int unsigned PARAM_NUM_LED         = 2,
   parameter int unsigned PARAM_RST_BTN         = 0,
   parameter int unsigned PARAM_DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned PARAM_STRETCH_CYCLES  = 5000000,
   parameter int unsigned PARAM_RST_HOLD_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pcileech_board_ctl_if.slave  bus
);

   localparam int unsigned              NB        = PARAM_NUM_BTN;
   localparam int unsigned              NL        = PARAM_NUM_LED;
   localparam int unsigned              HOLD_W    = cnt_width(PARAM_RST_HOLD_CYCLES);
   localparam logic [HOLD_W-1:0]        HOLD_LAST = HOLD_W'(PARAM_RST_HOLD_CYCLES - 1);
   localparam int unsigned              STR_W     = cnt_width(PARAM_STRETCH_CYCLES);
   localparam logic [STR_W-1:0]         STR_LOAD  = STR_W'(PARAM_STRETCH_CYCLES);
   localparam logic [NB-1:0]            RST_MASK  = NB'(1) << PARAM_RST_BTN;

   if (NB < 1) begin : g_chk_num_btn
      $error("pcileech_board_ctl: PARAM_NUM_BTN must be >= 1");
   end
   if (NL < 1) begin : g_chk_num_led
      $error("pcileech_board_ctl: PARAM_NUM_LED must be >= 1");
   end
   if (PARAM_RST_BTN >= NB) begin : g_chk_rst_btn
      $error("pcileech_board_ctl: PARAM_RST_BTN must be < PARAM_NUM_BTN");
   end
   if (PARAM_DEBOUNCE_CYCLES < 1 || PARAM_STRETCH_CYCLES < 1 || PARAM_RST_HOLD_CYCLES < 1) begin : g_chk_cycles
      $error("pcileech_board_ctl: cycle parameters must be >= 1");
   end

   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_level_d;
   logic [NL-1:0] led_q;

   for (genvar b = 0; b < NB; b++) begin : g_btn
      pcileech_debounce #(
         .CYCLES (PARAM_DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk     (clk),
         .rst_n   (rst_n),
         .btn_n   (bus.btn_n[b]),
         .level   (btn_level[b]),
         .press   (btn_press[b]),
         .level_d (btn_level_d[b])
      );
   end

   assign bus.btn_level = btn_level;
   assign bus.btn_press = btn_press;

   // ---------------- reset sequencer ----------------
   board_rst_state_t    state;
   board_rst_state_t    state_nxt;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [HOLD_W-1:0]   hold_nxt;
   logic                rst_btn;
   logic                rst_q;

   assign rst_btn = |(btn_level_d & RST_MASK);

   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      case (state)
         ST_HOLD: begin
            if (rst_btn) begin
               state_nxt = ST_BTN;
               hold_nxt  = '0;
            end else if (hold_cnt == HOLD_LAST) begin
               state_nxt = ST_RUN;
               hold_nxt  = '0;
            end else begin
               hold_nxt  = hold_cnt + 1'b1;
            end
         end
         ST_RUN: begin
            if (rst_btn) begin
               state_nxt = ST_BTN;
               hold_nxt  = '0;
            end
         end
         ST_BTN: begin
            if (!rst_btn) begin
               state_nxt = ST_HOLD;
               hold_nxt  = '0;
            end
         end
         default: begin
            state_nxt = ST_HOLD;
            hold_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_HOLD;
         hold_cnt <= '0;
         rst_q    <= 1'b1;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         rst_q    <= (state_nxt != ST_RUN);
      end
   end

   assign bus.rst_out = rst_q;

   // ---------------- LED stretchers ----------------
   for (genvar l = 0; l < NL; l++) begin : g_led
      logic [STR_W-1:0] cnt;
      logic             on_q;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            cnt  <= '0;
            on_q <= 1'b0;
         end else begin
            if (bus.led_act[l]) begin
               cnt <= STR_LOAD;
            end else if (cnt != '0) begin
               cnt <= cnt - 1'b1;
            end
            on_q <= ((cnt != '0) | bus.led_act[l]) ^ bus.led_invert;
         end
      end

      assign led_q[l] = on_q;
   end

   assign bus.led_out = led_q;

endmodule

// File: tb/tb_pcileech_board_ctl.sv
// Directed self-checking bench for pcileech_board_ctl (DEBOUNCE=4, STRETCH=8, RST_HOLD=3).
module tb_pcileech_board_ctl;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   pcileech_board_ctl_if #(.NUM_BTN(2), .NUM_LED(2)) bus_if ();

   pcileech_board_ctl #(
      .PARAM_NUM_BTN         (2),
      .PARAM_NUM_LED         (2),
      .PARAM_RST_BTN         (0),
      .PARAM_DEBOUNCE_CYCLES (4),
      .PARAM_STRETCH_CYCLES  (8),
      .PARAM_RST_HOLD_CYCLES (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus_if.btn_n = 2'b11;
      bus_if.led_act = 2'b00;
      bus_if.led_invert = 1'b0;
      tick();
      tick();
      checks++;
      if (bus_if.rst_out !== 1'b1) begin
         errors++;
         $display("FAIL reset_rst_out got %b exp 1", bus_if.rst_out);
      end
      checks++;
      if (bus_if.led_out !== 2'b00 || bus_if.btn_level !== 2'b00 || bus_if.btn_press !== 2'b00) begin
         errors++;
         $display("FAIL reset_outputs led=%b lvl=%b press=%b exp 00/00/00",
                  bus_if.led_out, bus_if.btn_level, bus_if.btn_press);
      end
      rst_n = 1'b1;
      for (int t = 1; t <= 6; t++) begin
         tick();
         checks++;
         if (bus_if.rst_out !== ((t < 3) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL reset_hold t=%0d got %b exp %b", t, bus_if.rst_out, (t < 3));
         end
         checks++;
         if (bus_if.led_out !== 2'b00 || bus_if.btn_level !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle t=%0d led=%b lvl=%b exp 00/00", t, bus_if.led_out, bus_if.btn_level);
         end
      end
   endtask

   task automatic test_debounce_bounce();
      for (int t = 1; t <= 20; t++) begin
         bus_if.btn_n[1] = (t == 3 || t >= 13) ? 1'b1 : 1'b0;
         tick();
         checks++;
         if (bus_if.btn_level[1] !== ((t >= 9 && t < 18) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL deb_level t=%0d got %b exp %b", t, bus_if.btn_level[1], (t >= 9 && t < 18));
         end
         checks++;
         if (bus_if.btn_press[1] !== ((t == 9) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL deb_press t=%0d got %b exp %b", t, bus_if.btn_press[1], (t == 9));
         end
         checks++;
         if (bus_if.rst_out !== 1'b0 || bus_if.btn_level[0] !== 1'b0) begin
            errors++;
            $display("FAIL deb_side t=%0d rst=%b lvl0=%b exp 0/0", t, bus_if.rst_out, bus_if.btn_level[0]);
         end
      end
   endtask

   task automatic test_rst_button();
      for (int t = 1; t <= 32; t++) begin
         bus_if.btn_n[0] = (t <= 20) ? 1'b0 : 1'b1;
         tick();
         checks++;
         if (bus_if.btn_level[0] !== ((t >= 6 && t <= 25) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL rstbtn_level t=%0d got %b exp %b", t, bus_if.btn_level[0], (t >= 6 && t <= 25));
         end
         checks++;
         if (bus_if.rst_out !== ((t >= 6 && t <= 28) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL rstbtn_rst_out t=%0d got %b exp %b", t, bus_if.rst_out, (t >= 6 && t <= 28));
         end
         checks++;
         if (bus_if.btn_press[0] !== ((t == 6) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL rstbtn_press t=%0d got %b exp %b", t, bus_if.btn_press[0], (t == 6));
         end
      end
   endtask

   task automatic test_led_stretch();
      for (int t = 1; t <= 12; t++) begin
         bus_if.led_act = (t == 1) ? 2'b01 : 2'b00;
         tick();
         checks++;
         if (bus_if.led_out !== {1'b0, (t <= 9)}) begin
            errors++;
            $display("FAIL led_single t=%0d got %b exp %b", t, bus_if.led_out, {1'b0, (t <= 9)});
         end
      end
      for (int t = 1; t <= 20; t++) begin
         bus_if.led_act = (t == 1 || t == 9) ? 2'b01 : 2'b00;
         tick();
         checks++;
         if (bus_if.led_out !== {1'b0, (t <= 17)}) begin
            errors++;
            $display("FAIL led_retrigger t=%0d got %b exp %b", t, bus_if.led_out, {1'b0, (t <= 17)});
         end
      end
   endtask

   task automatic test_led_invert();
      bus_if.led_invert = 1'b1;
      for (int t = 1; t <= 12; t++) begin
         bus_if.led_act = (t == 2) ? 2'b10 : 2'b00;
         tick();
         checks++;
         if (bus_if.led_out !== {!(t >= 2 && t <= 10), 1'b1}) begin
            errors++;
            $display("FAIL led_invert t=%0d got %b exp %b", t, bus_if.led_out, {!(t >= 2 && t <= 10), 1'b1});
         end
      end
      bus_if.led_invert = 1'b0;
      tick();
      checks++;
      if (bus_if.led_out !== 2'b00) begin
         errors++;
         $display("FAIL led_uninvert got %b exp 00", bus_if.led_out);
      end
   endtask

   task automatic test_reset_mid();
      for (int t = 1; t <= 5; t++) begin
         bus_if.led_act = (t == 1) ? 2'b01 : 2'b00;
         bus_if.btn_n = 2'b01;
         tick();
      end
      checks++;
      if (bus_if.led_out !== 2'b01 || bus_if.btn_level !== 2'b00) begin
         errors++;
         $display("FAIL mid_pre led=%b lvl=%b exp 01/00", bus_if.led_out, bus_if.btn_level);
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if (bus_if.led_out !== 2'b00 || bus_if.btn_level !== 2'b00 || bus_if.rst_out !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset led=%b lvl=%b rst=%b exp 00/00/1",
                  bus_if.led_out, bus_if.btn_level, bus_if.rst_out);
      end
      rst_n = 1'b1;
      bus_if.btn_n = 2'b11;
      for (int t = 1; t <= 4; t++) begin
         tick();
         checks++;
         if (bus_if.rst_out !== ((t < 3) ? 1'b1 : 1'b0) || bus_if.led_out !== 2'b00) begin
            errors++;
            $display("FAIL mid_recover t=%0d rst=%b led=%b exp %b/00", t, bus_if.rst_out, bus_if.led_out, (t < 3));
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_debounce_bounce();
      test_rst_button();
      test_led_stretch();
      test_led_invert();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
